// File: rtl/mem_port_arbiter_if.sv
// Bundle between the LSQ / data memory side (master) and the memory port arbiter (slave).
// Requests are level-held until the matching one-cycle *_gnt; *_done and mem_req_valid are one-cycle strobes.
interface mem_port_arbiter_if;
    logic        st_req;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [2:0]  st_func3;
    logic [4:0]  st_rob_tag;
    logic        st_gnt;

    logic        ld_req;
    logic [31:0] ld_addr;
    logic [2:0]  ld_func3;
    logic [6:0]  ld_pd;
    logic [4:0]  ld_rob_tag;
    logic        ld_gnt;

    logic        mispredict;

    logic        mem_req_valid;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_func3;
    logic [31:0] mem_rdata;

    logic        ld_done;
    logic [31:0] ld_data;
    logic [6:0]  ld_pd_out;
    logic [4:0]  ld_rob_out;
    logic        st_done;
    logic [4:0]  st_rob_out;
    logic        busy;
    logic [1:0]  state_dbg;

    modport master (
        output st_req, st_addr, st_data, st_func3, st_rob_tag,
        output ld_req, ld_addr, ld_func3, ld_pd, ld_rob_tag,
        output mispredict, mem_rdata,
        input  st_gnt, ld_gnt, mem_req_valid, mem_we, mem_addr, mem_wdata, mem_func3,
        input  ld_done, ld_data, ld_pd_out, ld_rob_out, st_done, st_rob_out, busy, state_dbg
    );

    modport slave (
        input  st_req, st_addr, st_data, st_func3, st_rob_tag,
        input  ld_req, ld_addr, ld_func3, ld_pd, ld_rob_tag,
        input  mispredict, mem_rdata,
        output st_gnt, ld_gnt, mem_req_valid, mem_we, mem_addr, mem_wdata, mem_func3,
        output ld_done, ld_data, ld_pd_out, ld_rob_out, st_done, st_rob_out, busy, state_dbg
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-ported data memory sequencer: arbitrates store drains against loads, issues one access
// at a time, waits out MEM_LAT and returns registered completions (squashed loads are dropped).
module mem_port_arbiter #(
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input logic               clk,
    input logic               reset,
    mem_port_arbiter_if.slave bus
);
    localparam int CW = $clog2(MEM_LAT + 1);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(MEM_LAT);
    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        STORE = 2'd2
    } state_t;

    state_t        state, next_state;
    logic [CW-1:0] cnt;
    logic [SW-1:0] starve;
    logic          kill;
    logic          st_win, ld_win, last_beat;

    logic [31:0] addr_q, wdata_q;
    logic [2:0]  func3_q;
    logic [6:0]  pd_q;
    logic [4:0]  rob_q;

    logic        ld_done_q, st_done_q;
    logic [31:0] ld_data_q;
    logic [6:0]  ld_pd_q;
    logic [4:0]  ld_rob_q, st_rob_q;

    // Grants are combinational in IDLE; reset masks them so every output reads 0 while held.
    always_comb begin
        st_win     = 1'b0;
        ld_win     = 1'b0;
        next_state = state;
        last_beat  = (state != IDLE) && (cnt == CNT_LAST);
        case (state)
            IDLE: begin
                if (!reset && bus.st_req && (!bus.ld_req || starve == STARVE_TOP)) begin
                    st_win     = 1'b1;
                    next_state = STORE;
                end else if (!reset && bus.ld_req && !bus.mispredict) begin
                    ld_win     = 1'b1;
                    next_state = LOAD;
                end
            end
            LOAD, STORE: begin
                if (last_beat) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            starve    <= '0;
            kill      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            func3_q   <= '0;
            pd_q      <= '0;
            rob_q     <= '0;
            ld_done_q <= 1'b0;
            st_done_q <= 1'b0;
            ld_data_q <= '0;
            ld_pd_q   <= '0;
            ld_rob_q  <= '0;
            st_rob_q  <= '0;
        end else begin
            ld_done_q <= 1'b0;
            st_done_q <= 1'b0;

            if (state == IDLE || last_beat) cnt <= '0;
            else                            cnt <= cnt + CW'(1);

            if (st_win) begin
                addr_q  <= bus.st_addr;
                wdata_q <= bus.st_data;
                func3_q <= bus.st_func3;
                rob_q   <= bus.st_rob_tag;
            end else if (ld_win) begin
                addr_q  <= bus.ld_addr;
                func3_q <= bus.ld_func3;
                pd_q    <= bus.ld_pd;
                rob_q   <= bus.ld_rob_tag;
            end

            if (st_win)
                starve <= '0;
            else if (state == IDLE && bus.st_req && starve != STARVE_TOP)
                starve <= starve + SW'(1);

            // A squashed load still occupies the port until its latency elapses.
            if (state != LOAD || last_beat) kill <= 1'b0;
            else if (bus.mispredict)        kill <= 1'b1;

            if (state == LOAD && last_beat && !kill && !bus.mispredict) begin
                ld_done_q <= 1'b1;
                ld_data_q <= bus.mem_rdata;
                ld_pd_q   <= pd_q;
                ld_rob_q  <= rob_q;
            end

            if (state == STORE && last_beat) begin
                st_done_q <= 1'b1;
                st_rob_q  <= rob_q;
            end
        end
    end

    assign bus.st_gnt        = st_win;
    assign bus.ld_gnt        = ld_win;
    assign bus.mem_req_valid = (state != IDLE) && (cnt == '0);
    assign bus.mem_we        = (state == STORE);
    assign bus.mem_addr      = addr_q;
    assign bus.mem_wdata     = wdata_q;
    assign bus.mem_func3     = func3_q;
    assign bus.ld_done       = ld_done_q && !bus.mispredict;
    assign bus.ld_data       = ld_data_q;
    assign bus.ld_pd_out     = ld_pd_q;
    assign bus.ld_rob_out    = ld_rob_q;
    assign bus.st_done       = st_done_q;
    assign bus.st_rob_out    = st_rob_q;
    assign bus.busy          = (state != IDLE);
    assign bus.state_dbg     = state;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (MEM_LAT=2, STARVE_MAX=4): grants, memory issues and
// completions are checked by a negedge monitor against cycle-stamped expected queues.
module tb_mem_port_arbiter;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_port_arbiter_if bus();

    mem_port_arbiter #(.MEM_LAT(LAT), .STARVE_MAX(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int rd_issue = -100;
    logic [31:0] rd_val = 32'h0;

    logic [127:0] gnt_q[$];
    logic [127:0] iss_q[$];
    logic [127:0] done_q[$];

    always @(posedge clk) cyc++;

    // Memory model: read data is valid only in the cycle LAT after the load issue.
    always @(posedge clk) begin
        #1;
        bus.mem_rdata = (cyc == rd_issue + LAT) ? rd_val : 32'hBADBAD00;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [127:0] outs();
        return {bus.state_dbg, bus.st_gnt, bus.ld_gnt, bus.mem_req_valid, bus.mem_we,
                bus.mem_addr, bus.mem_wdata, bus.mem_func3, bus.ld_done, bus.ld_data,
                bus.ld_pd_out, bus.ld_rob_out, bus.st_done, bus.st_rob_out, bus.busy};
    endfunction

    // Monitor: every strobe the DUT presents must match the head of its expected queue.
    always @(negedge clk) begin
        if (bus.st_gnt || bus.ld_gnt) begin
            if (gnt_q.size() == 0) check("grant_unexpected", {bus.st_gnt, bus.ld_gnt, cyc}, 128'h0);
            else                   check("grant", {bus.st_gnt, bus.ld_gnt, cyc}, gnt_q.pop_front());
        end
        if (bus.mem_req_valid) begin
            if (!bus.mem_we) rd_issue = cyc;
            if (iss_q.size() == 0)
                check("issue_unexpected", {bus.mem_we, bus.mem_addr, cyc}, 128'h0);
            else
                check("issue", {bus.mem_we, bus.mem_addr, (bus.mem_we ? bus.mem_wdata : 32'h0),
                                bus.mem_func3, cyc}, iss_q.pop_front());
        end
        if (bus.ld_done || bus.st_done) begin
            if (done_q.size() == 0)
                check("done_unexpected", {bus.ld_done, bus.st_done, cyc}, 128'h0);
            else
                check("done", {bus.ld_done, bus.st_done,
                               (bus.ld_done ? bus.ld_data : 32'h0),
                               (bus.ld_done ? bus.ld_pd_out : 7'h0),
                               (bus.ld_done ? bus.ld_rob_out : bus.st_rob_out), cyc},
                      done_q.pop_front());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic goto(input int t);
        while (cyc < t) step();
    endtask

    task automatic clear_inputs();
        bus.st_req = 1'b0; bus.st_addr = '0; bus.st_data = '0; bus.st_func3 = '0; bus.st_rob_tag = '0;
        bus.ld_req = 1'b0; bus.ld_addr = '0; bus.ld_func3 = '0; bus.ld_pd = '0; bus.ld_rob_tag = '0;
        bus.mispredict = 1'b0;
    endtask

    task automatic drive_ld(input logic [31:0] a, input logic [2:0] f, input logic [6:0] pd,
                            input logic [4:0] rob);
        bus.ld_req = 1'b1; bus.ld_addr = a; bus.ld_func3 = f; bus.ld_pd = pd; bus.ld_rob_tag = rob;
    endtask

    task automatic drive_st(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f,
                            input logic [4:0] rob);
        bus.st_req = 1'b1; bus.st_addr = a; bus.st_data = d; bus.st_func3 = f; bus.st_rob_tag = rob;
    endtask

    task automatic exp_gnt(input logic st, input logic ld, input int c);
        gnt_q.push_back({st, ld, 32'(c)});
    endtask

    task automatic exp_issue(input logic we, input logic [31:0] a, input logic [31:0] d,
                             input logic [2:0] f, input int c);
        iss_q.push_back({we, a, d, f, 32'(c)});
    endtask

    task automatic exp_ld_done(input logic [31:0] d, input logic [6:0] pd, input logic [4:0] rob,
                               input int c);
        done_q.push_back({1'b1, 1'b0, d, pd, rob, 32'(c)});
    endtask

    task automatic exp_st_done(input logic [4:0] rob, input int c);
        done_q.push_back({1'b0, 1'b1, 32'h0, 7'h0, rob, 32'(c)});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        reset = 1'b1;
        clear_inputs();
        bus.mem_rdata = 32'h0;
        step();
        bus.st_req = 1'b1;
        bus.ld_req = 1'b1;
        #1;
        check("reset_outputs", outs(), 128'h0);
        clear_inputs();
        step();
        reset = 1'b0;
        step();

        // Lone load
        c = cyc; rd_val = 32'hDEADBEEF;
        drive_ld(32'h40, 3'd2, 7'd12, 5'd3);
        exp_gnt(1'b0, 1'b1, c);
        exp_issue(1'b0, 32'h40, 32'h0, 3'd2, c + 1);
        exp_ld_done(32'hDEADBEEF, 7'd12, 5'd3, c + 4);
        step();
        bus.ld_req = 1'b0;
        goto(c + 5);

        // Lone store
        c = cyc;
        drive_st(32'h80, 32'h55, 3'd0, 5'd7);
        exp_gnt(1'b1, 1'b0, c);
        exp_issue(1'b1, 32'h80, 32'h55, 3'd0, c + 1);
        exp_st_done(5'd7, c + 4);
        step();
        bus.st_req = 1'b0;
        goto(c + 5);

        // Starvation: four loads win, then the store; starve is cleared afterwards
        c = cyc; rd_val = 32'h11112222;
        drive_ld(32'h200, 3'd4, 7'd20, 5'd1);
        drive_st(32'h100, 32'hA5A5A5A5, 3'd1, 5'd9);
        for (int k = 0; k < 4; k++) begin
            exp_gnt(1'b0, 1'b1, c + 4 * k);
            exp_issue(1'b0, 32'h200, 32'h0, 3'd4, c + 4 * k + 1);
            exp_ld_done(32'h11112222, 7'd20, 5'd1, c + 4 * k + 4);
        end
        exp_gnt(1'b1, 1'b0, c + 16);
        exp_issue(1'b1, 32'h100, 32'hA5A5A5A5, 3'd1, c + 17);
        exp_st_done(5'd9, c + 20);
        exp_gnt(1'b0, 1'b1, c + 20);
        exp_issue(1'b0, 32'h200, 32'h0, 3'd4, c + 21);
        exp_ld_done(32'h11112222, 7'd20, 5'd1, c + 24);
        exp_gnt(1'b1, 1'b0, c + 24);
        exp_issue(1'b1, 32'h100, 32'hA5A5A5A5, 3'd1, c + 25);
        exp_st_done(5'd9, c + 28);
        goto(c + 17);
        bus.st_req = 1'b0;
        goto(c + 20);
        bus.st_req = 1'b1;
        goto(c + 21);
        bus.ld_req = 1'b0;
        goto(c + 25);
        bus.st_req = 1'b0;
        goto(c + 29);

        // Flush of an in-flight load; pending store granted when the port frees
        c = cyc;
        drive_ld(32'h300, 3'd2, 7'd5, 5'd4);
        exp_gnt(1'b0, 1'b1, c);
        exp_issue(1'b0, 32'h300, 32'h0, 3'd2, c + 1);
        exp_gnt(1'b1, 1'b0, c + 4);
        exp_issue(1'b1, 32'h400, 32'h77, 3'd0, c + 5);
        exp_st_done(5'd11, c + 8);
        step();
        bus.ld_req = 1'b0;
        drive_st(32'h400, 32'h77, 3'd0, 5'd11);
        step();
        bus.mispredict = 1'b1;
        step();
        bus.mispredict = 1'b0;
        check("busy_in_flight", bus.busy, 1'b1);
        step();
        check("busy_fall", bus.busy, 1'b0);
        step();
        bus.st_req = 1'b0;
        goto(c + 9);

        // Mispredict while a load waits in IDLE: grant deferred one cycle
        c = cyc; rd_val = 32'hCAFEF00D;
        drive_ld(32'h500, 3'd1, 7'd33, 5'd6);
        bus.mispredict = 1'b1;
        #1;
        check("no_gnt_mispredict", bus.ld_gnt, 1'b0);
        exp_gnt(1'b0, 1'b1, c + 1);
        exp_issue(1'b0, 32'h500, 32'h0, 3'd1, c + 2);
        exp_ld_done(32'hCAFEF00D, 7'd33, 5'd6, c + 5);
        step();
        bus.mispredict = 1'b0;
        step();
        bus.ld_req = 1'b0;
        goto(c + 6);

        // Mispredict coinciding with the load done cycle suppresses it
        c = cyc; rd_val = 32'h0BADF00D;
        drive_ld(32'h600, 3'd5, 7'd50, 5'd8);
        exp_gnt(1'b0, 1'b1, c);
        exp_issue(1'b0, 32'h600, 32'h0, 3'd5, c + 1);
        step();
        bus.ld_req = 1'b0;
        goto(c + 4);
        bus.mispredict = 1'b1;
        #1;
        check("ld_done_masked", bus.ld_done, 1'b0);
        step();
        bus.mispredict = 1'b0;
        goto(c + 6);

        // Reset during a store: outputs clear at once and no completion follows
        c = cyc;
        drive_st(32'h700, 32'h99, 3'd2, 5'd13);
        exp_gnt(1'b1, 1'b0, c);
        exp_issue(1'b1, 32'h700, 32'h99, 3'd2, c + 1);
        step();
        bus.st_req = 1'b0;
        step();
        reset = 1'b1;
        #1;
        check("reset_mid_store", outs(), 128'h0);
        step();
        step();
        reset = 1'b0;
        step();
        check("post_reset_idle", outs(), 128'h0);
        goto(cyc + 6);

        check("grant_queue_drained", 128'(gnt_q.size()), 128'h0);
        check("issue_queue_drained", 128'(iss_q.size()), 128'h0);
        check("done_queue_drained", 128'(done_q.size()), 128'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
